// File: rtl/dpwm_multiphase_if.sv
// dpwm_multiphase_if: configuration inputs and gate/status outputs of the
// multiphase DPWM, grouped so the modulator and its controller share one bundle.
//   master: drives en, ss_en, i_period, i_duty, i_duty_max, i_dt1, i_dt2;
//           receives o_hs, o_ls, o_sync, o_ss_done.
//   slave : the modulator side (mirror of master).
interface dpwm_multiphase_if #(
  parameter int CNT_W = 8,
  parameter int N_PH  = 2,
  parameter int DT_W  = 4
);
  logic             en;
  logic             ss_en;
  logic [CNT_W-1:0] i_period;
  logic [CNT_W-1:0] i_duty;
  logic [CNT_W-1:0] i_duty_max;
  logic [DT_W-1:0]  i_dt1;
  logic [DT_W-1:0]  i_dt2;
  logic [N_PH-1:0]  o_hs;
  logic [N_PH-1:0]  o_ls;
  logic             o_sync;
  logic             o_ss_done;

  modport master (
    output en, ss_en, i_period, i_duty, i_duty_max, i_dt1, i_dt2,
    input  o_hs, o_ls, o_sync, o_ss_done
  );

  modport slave (
    input  en, ss_en, i_period, i_duty, i_duty_max, i_dt1, i_dt2,
    output o_hs, o_ls, o_sync, o_ss_done
  );
endinterface

// File: rtl/dpwm_multiphase.sv
// dpwm_multiphase: N-phase interleaved digital PWM with complementary gate
// outputs, per-edge dead time, duty clamp and soft-start ramp. Period, duty,
// dead times and phase offsets are shadowed and change only at a period wrap.
// Ports:
//   clk  - modulator clock
//   rst  - synchronous active-high reset
//   bus  - dpwm_multiphase_if.slave (enable/config in, gates/sync/ss_done out)
module dpwm_multiphase #(
  parameter int CNT_W  = 8,
  parameter int N_PH   = 2,
  parameter int DT_W   = 4,
  parameter int SS_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  dpwm_multiphase_if.slave  bus
);
  // state  | meaning
  // ST_OFF | disabled, or first enabled edge: load shadows, cnt=0, outputs 0
  // ST_RUN | modulating; shadows reload at every counter wrap
  typedef enum logic {ST_OFF, ST_RUN} state_t;

  localparam int PW  = CNT_W + 1;
  localparam int MW  = CNT_W + 4;
  localparam int LG  = $clog2(N_PH);
  localparam int SSW = (SS_DIV > 1) ? $clog2(SS_DIV) : 1;
  localparam logic [DT_W:0] RL_MAX = {1'b1, {DT_W{1'b0}}};
  localparam logic [DT_W:0] RL_ONE = {{DT_W{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [DT_W-1:0]  dt1_q, dt1_d, dt2_q, dt2_d;
  logic [PW-1:0]    off_q [N_PH];
  logic [PW-1:0]    off_d [N_PH];
  logic [CNT_W-1:0] ss_duty_q, ss_duty_d;
  logic [SSW-1:0]   ss_cnt_q, ss_cnt_d;
  logic             reached_q, reached_d;
  logic [DT_W:0]    rl_hi_q [N_PH];
  logic [DT_W:0]    rl_hi_d [N_PH];
  logic [DT_W:0]    rl_lo_q [N_PH];
  logic [DT_W:0]    rl_lo_d [N_PH];
  logic [N_PH-1:0]  hs_q, hs_d, ls_q, ls_d;
  logic             sync_q, sync_d, done_q, done_d;

  logic [CNT_W-1:0] tgt, duty_ld;
  logic [PW-1:0]    per1_cur, per1_new;
  logic [PW-1:0]    off_new [N_PH];
  logic [PW-1:0]    sum [N_PH];
  logic [PW-1:0]    pc [N_PH];
  logic [DT_W:0]    hi_run [N_PH];
  logic [DT_W:0]    lo_run [N_PH];
  logic [N_PH-1:0]  pwm;
  logic             wrap, load;

  // Per-phase compare path and run lengths including the current cycle.
  always_comb begin
    tgt      = (bus.i_duty < bus.i_duty_max) ? bus.i_duty : bus.i_duty_max;
    // Shadow load always sees the pre-increment ramp value.
    duty_ld  = (bus.ss_en && (ss_duty_q < tgt)) ? ss_duty_q : tgt;
    per1_cur = {1'b0, per_q} + PW'(1);
    per1_new = {1'b0, bus.i_period} + PW'(1);
    wrap     = (cnt_q == per_q);
    pwm      = '0;
    off_new  = '{default: '0};
    sum      = '{default: '0};
    pc       = '{default: '0};
    hi_run   = '{default: '0};
    lo_run   = '{default: '0};
    for (int k = 0; k < N_PH; k++) begin
      off_new[k] = PW'((MW'(per1_new) * MW'(k)) >> LG);
      sum[k]     = {1'b0, cnt_q} + off_q[k];
      pc[k]      = (sum[k] >= per1_cur) ? sum[k] - per1_cur : sum[k];
      pwm[k]     = (pc[k] < {1'b0, duty_q});
      hi_run[k]  = !pwm[k] ? '0 :
                   ((rl_hi_q[k] == RL_MAX) ? RL_MAX : rl_hi_q[k] + RL_ONE);
      lo_run[k]  = pwm[k] ? '0 :
                   ((rl_lo_q[k] == RL_MAX) ? RL_MAX : rl_lo_q[k] + RL_ONE);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    duty_d    = duty_q;
    dt1_d     = dt1_q;
    dt2_d     = dt2_q;
    off_d     = off_q;
    ss_duty_d = ss_duty_q;
    ss_cnt_d  = ss_cnt_q;
    reached_d = reached_q;
    rl_hi_d   = rl_hi_q;
    rl_lo_d   = rl_lo_q;
    hs_d      = '0;
    ls_d      = '0;
    sync_d    = 1'b0;
    done_d    = 1'b0;
    load      = 1'b0;
    if (bus.en) begin
      // Sticky: a later drop of the target does not clear done.
      reached_d = reached_q | (ss_duty_q >= tgt);
      done_d    = !bus.ss_en | reached_d;
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_RUN;
          cnt_d   = '0;
          load    = 1'b1;
          rl_hi_d = '{default: '0};
          rl_lo_d = '{default: '0};
        end
        ST_RUN: begin
          rl_hi_d = hi_run;
          rl_lo_d = lo_run;
          for (int k = 0; k < N_PH; k++) begin
            hs_d[k] = (hi_run[k] > {1'b0, dt1_q});
            ls_d[k] = (lo_run[k] > {1'b0, dt2_q});
          end
          sync_d = (cnt_q == '0);
          if (wrap) begin
            cnt_d = '0;
            load  = 1'b1;
            if (ss_cnt_q == SSW'(SS_DIV - 1)) begin
              ss_cnt_d = '0;
              if (ss_duty_q < tgt) ss_duty_d = ss_duty_q + CNT_W'(1);
            end else begin
              ss_cnt_d = ss_cnt_q + SSW'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
      if (load) begin
        per_d  = bus.i_period;
        duty_d = duty_ld;
        dt1_d  = bus.i_dt1;
        dt2_d  = bus.i_dt2;
        off_d  = off_new;
      end
    end else begin
      state_d   = ST_OFF;
      cnt_d     = '0;
      per_d     = '0;
      duty_d    = '0;
      dt1_d     = '0;
      dt2_d     = '0;
      off_d     = '{default: '0};
      ss_duty_d = '0;
      ss_cnt_d  = '0;
      reached_d = 1'b0;
      rl_hi_d   = '{default: '0};
      rl_lo_d   = '{default: '0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      per_q     <= '0;
      duty_q    <= '0;
      dt1_q     <= '0;
      dt2_q     <= '0;
      off_q     <= '{default: '0};
      ss_duty_q <= '0;
      ss_cnt_q  <= '0;
      reached_q <= 1'b0;
      rl_hi_q   <= '{default: '0};
      rl_lo_q   <= '{default: '0};
      hs_q      <= '0;
      ls_q      <= '0;
      sync_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      duty_q    <= duty_d;
      dt1_q     <= dt1_d;
      dt2_q     <= dt2_d;
      off_q     <= off_d;
      ss_duty_q <= ss_duty_d;
      ss_cnt_q  <= ss_cnt_d;
      reached_q <= reached_d;
      rl_hi_q   <= rl_hi_d;
      rl_lo_q   <= rl_lo_d;
      hs_q      <= hs_d;
      ls_q      <= ls_d;
      sync_q    <= sync_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_hs      = hs_q;
  assign bus.o_ls      = ls_q;
  assign bus.o_sync    = sync_q;
  assign bus.o_ss_done = done_q;
endmodule

// File: tb/tb_dpwm_multiphase.sv
// Testbench for dpwm_multiphase: directed scenarios followed by randomized
// segments. A cycle-level reference model built from the period/duty/dead-time
// rules pushes the expected outputs for each edge into a queue; a monitor on
// the falling edge pops and compares.
module tb_dpwm_multiphase;
  localparam int CNT_W  = 8;
  localparam int N_PH   = 2;
  localparam int DT_W   = 4;
  localparam int SS_DIV = 4;
  localparam int EW     = 2 * N_PH + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dpwm_multiphase_if #(.CNT_W(CNT_W), .N_PH(N_PH), .DT_W(DT_W)) bus ();

  dpwm_multiphase #(.CNT_W(CNT_W), .N_PH(N_PH), .DT_W(DT_W), .SS_DIV(SS_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [EW-1:0] exp_q [$];

  // Reference model state: "current cycle" view before the next edge.
  bit  m_act;
  int  m_cnt, m_per, m_d, m_dt1, m_dt2, m_ss, m_wr;
  bit  m_reached;
  int  m_off [N_PH];
  logic [N_PH-1:0] hist [$];   // pwm vector of each enabled cycle, newest last

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // True when the newest n history entries all hold value v on phase k.
  function automatic bit win(input int k, input int n, input bit v);
    if (hist.size() < n) return 1'b0;
    for (int i = hist.size() - n; i < hist.size(); i++)
      if (hist[i][k] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load_shadows(input int ss_v, input int tgt);
    m_per = int'(bus.i_period);
    m_dt1 = int'(bus.i_dt1);
    m_dt2 = int'(bus.i_dt2);
    m_d   = bus.ss_en ? imin(ss_v, tgt) : tgt;
    for (int k = 0; k < N_PH; k++) m_off[k] = ((m_per + 1) * k) / N_PH;
  endtask

  task automatic model_edge(output logic [EW-1:0] e);
    int tgt, ss_pre, pc;
    logic [N_PH-1:0] pw, hs, ls;
    logic sy, dn;
    tgt = imin(int'(bus.i_duty), int'(bus.i_duty_max));
    hs = '0; ls = '0; pw = '0; sy = 1'b0; dn = 1'b0;
    if (rst || !bus.en) begin
      m_act = 0; m_cnt = 0; m_per = 0; m_d = 0; m_dt1 = 0; m_dt2 = 0;
      m_ss = 0; m_wr = 0; m_reached = 0;
      for (int k = 0; k < N_PH; k++) m_off[k] = 0;
      hist.delete();
    end else begin
      ss_pre    = m_ss;
      m_reached = m_reached || (ss_pre >= tgt);
      dn        = !bus.ss_en || m_reached;
      if (!m_act) begin
        m_act = 1; m_cnt = 0;
        hist.delete();
        load_shadows(ss_pre, tgt);
      end else begin
        for (int k = 0; k < N_PH; k++) begin
          pc = m_cnt + m_off[k];
          if (pc >= m_per + 1) pc = pc - (m_per + 1);
          pw[k] = (pc < m_d);
        end
        hist.push_back(pw);
        if (hist.size() > 20) void'(hist.pop_front());
        for (int k = 0; k < N_PH; k++) begin
          hs[k] = win(k, m_dt1 + 1, 1'b1);
          ls[k] = win(k, m_dt2 + 1, 1'b0);
        end
        sy = (m_cnt == 0);
        if (m_cnt == m_per) begin
          m_wr++;
          if (m_wr == SS_DIV) begin
            m_wr = 0;
            if (m_ss < tgt) m_ss++;
          end
          load_shadows(ss_pre, tgt);
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
    e = {hs, ls, sy, dn};
  endtask

  task automatic step();
    logic [EW-1:0] e;
    model_edge(e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e, a;
      e = exp_q.pop_front();
      a = {bus.o_hs, bus.o_ls, bus.o_sync, bus.o_ss_done};
      n_checks++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs @%0t: got hs=%b ls=%b sync=%b done=%b, expected hs=%b ls=%b sync=%b done=%b",
                 $time, a[EW-1 -: N_PH], a[N_PH+1 -: N_PH], a[1], a[0],
                 e[EW-1 -: N_PH], e[N_PH+1 -: N_PH], e[1], e[0]);
      end
      n_checks++;
      if ((bus.o_hs & bus.o_ls) !== '0) begin
        n_err++;
        $display("FAIL overlap @%0t: hs=%b ls=%b, expected no common bit", $time, bus.o_hs, bus.o_ls);
      end
    end
  end

  initial begin
    int len;
    rst = 1'b1;
    bus.en = 1'b1; bus.ss_en = 1'b0;
    bus.i_period = 8'd99; bus.i_duty = 8'd50; bus.i_duty_max = 8'd255;
    bus.i_dt1 = '0; bus.i_dt2 = '0;
    repeat (3) step();
    rst = 1'b0;
    // Steady state, no dead time
    repeat (300) step();
    // Dead time
    bus.i_dt1 = 4'd3; bus.i_dt2 = 4'd5;
    repeat (300) step();
    // Mid-period duty change, zero duty, clamp
    repeat (30) step();
    bus.i_duty = 8'd20;
    repeat (200) step();
    bus.i_duty = 8'd0;
    repeat (200) step();
    bus.i_duty = 8'd200; bus.i_duty_max = 8'd80;
    repeat (200) step();
    // Disable mid-period, re-enable with soft start
    repeat (25) step();
    bus.en = 1'b0;
    repeat (3) step();
    bus.i_period = 8'd19; bus.i_duty = 8'd10; bus.i_duty_max = 8'd255;
    bus.i_dt1 = 4'd1; bus.i_dt2 = 4'd1; bus.ss_en = 1'b1; bus.en = 1'b1;
    repeat (1000) step();
    // Single-cycle period
    bus.ss_en = 1'b0; bus.i_period = 8'd0; bus.i_duty = 8'd1;
    repeat (20) step();
    bus.i_duty = 8'd0;
    repeat (20) step();
    // Randomized segments
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
      end
      bus.i_period   = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 3))
                                                   : CNT_W'($urandom_range(4, 60));
      bus.i_duty     = CNT_W'($urandom_range(0, int'(bus.i_period) + 4));
      bus.i_duty_max = ($urandom_range(0, 1) == 0) ? 8'd255 : CNT_W'($urandom_range(0, 64));
      bus.i_dt1      = DT_W'($urandom_range(0, 15));
      bus.i_dt2      = DT_W'($urandom_range(0, 15));
      bus.ss_en      = 1'($urandom_range(0, 1));
      bus.en         = 1'b1;
      len = $urandom_range(30, 300);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 99) < 3) bus.i_duty = CNT_W'($urandom_range(0, 70));
        if ($urandom_range(0, 99) < 2) bus.i_dt1 = DT_W'($urandom_range(0, 6));
        if ($urandom_range(0, 199) == 0) bus.en = ~bus.en;
        if ($urandom_range(0, 199) == 0) bus.ss_en = ~bus.ss_en;
        step();
      end
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
